// File: rtl/multiplier_8bit_seq_pkg.sv
// Shared definitions for the sequential 8x8 multiplier.
// State encodings, step sizing and per-step partial-product shifts.
package multiplier_8bit_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int STEP_W     = 2;
    localparam int STEP_COUNT = 4;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_COUNT - 1);

    // Weight of each nibble product: lo*lo, hi*lo, lo*hi, hi*hi.
    function automatic logic [3:0] shift_amt(input logic [STEP_W-1:0] s);
        logic [3:0] r;
        unique case (s)
            2'd0:    r = 4'd0;
            2'd1:    r = 4'd4;
            2'd2:    r = 4'd4;
            default: r = 4'd8;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multiplier_8bit_seq_core.sv
// Combinational 4x4 unsigned multiplier core.
// Ports: A, B (4-bit operands), PRODUCT (8-bit result).
module multiplier_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] PRODUCT
);

    assign PRODUCT = {4'b0, A} * {4'b0, B};

endmodule

// File: rtl/multiplier_8bit_seq.sv
// Sequential 8x8 unsigned multiplier time-sharing one 4x4 core.
// Ports: clk, rst, START, A, B in; BUSY, DONE, PRODUCT out.
module multiplier_8bit_seq
    import multiplier_8bit_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        START,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] PRODUCT
);

    state_t            state;
    state_t            state_next;
    logic [STEP_W-1:0] step;
    logic [7:0]        a_reg;
    logic [7:0]        b_reg;
    logic [15:0]       acc;
    logic [15:0]       prod_reg;
    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [7:0]        pp;
    logic [15:0]       pp_shifted;
    logic              accept;

    // START is honoured whenever no multiply is running, including FIN.
    assign accept = START && (state != MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (START) state_next = MUL;
            end
            MUL: begin
                if (step == STEP_LAST) state_next = FIN;
            end
            FIN: begin
                state_next = START ? MUL : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == MUL);
        DONE = (state == FIN);
    end

    // step[0] picks the A nibble, step[1] the B nibble.
    always_comb begin
        nib_a = step[0] ? a_reg[7:4] : a_reg[3:0];
        nib_b = step[1] ? b_reg[7:4] : b_reg[3:0];
    end

    multiplier_4bit u_core (
        .A       (nib_a),
        .B       (nib_b),
        .PRODUCT (pp)
    );

    assign pp_shifted = {8'b0, pp} << shift_amt(step);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            step     <= '0;
            prod_reg <= '0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= B;
            acc   <= '0;
            step  <= '0;
        end else if (state == MUL) begin
            acc  <= acc + pp_shifted;
            step <= step + 1'b1;
            if (step == STEP_LAST) begin
                prod_reg <= acc + pp_shifted;
            end
        end
    end

    assign PRODUCT = prod_reg;

endmodule

// File: tb/tb_multiplier_8bit_seq.sv
// Self-checking bench for multiplier_8bit_seq.
// Scoreboard queue of expected products, checked on each DONE.
module tb_multiplier_8bit_seq;

    logic        clk;
    logic        rst;
    logic        START;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        BUSY;
    logic        DONE;
    logic [15:0] PRODUCT;

    logic [15:0] sb_q[$];
    logic [15:0] last_prod;
    int          n_chk;
    int          n_fail;
    int          n_done;
    int          cycle;
    int          last_done_cycle;

    multiplier_8bit_seq dut (
        .clk     (clk),
        .rst     (rst),
        .START   (START),
        .A       (A),
        .B       (B),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .PRODUCT (PRODUCT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge.
    task automatic cyc();
        logic [15:0] e;
        @(posedge clk);
        #1;
        cycle++;
        if (DONE) begin
            chk("done_expected", 16'(sb_q.size() > 0), 16'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("product", PRODUCT, e);
                last_prod = e;
            end
            n_done++;
            last_done_cycle = cycle;
        end else begin
            chk("product_hold", PRODUCT, last_prod);
        end
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        START = 1'b1;
        A = a;
        B = b;
        sb_q.push_back(16'(a) * 16'(b));
        cyc();
        START = 1'b0;
        chk("busy_after_start", {15'b0, BUSY}, 16'd1);
    endtask

    // Full transaction with latency / pulse width checks.
    task automatic run_one(input logic [7:0] a, input logic [7:0] b);
        int d0;
        d0 = n_done;
        launch(a, b);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("busy_mid", {15'b0, BUSY}, 16'd1);
            chk("done_early", {15'b0, DONE}, 16'd0);
        end
        cyc();
        chk("done_pulse", {15'b0, DONE}, 16'd1);
        chk("busy_at_done", {15'b0, BUSY}, 16'd0);
        cyc();
        chk("done_one_cycle", {15'b0, DONE}, 16'd0);
        chk("done_count", 16'(n_done - d0), 16'd1);
    endtask

    initial begin
        int d0;
        n_chk = 0;
        n_fail = 0;
        n_done = 0;
        cycle = 0;
        last_done_cycle = 0;
        last_prod = 16'h0000;
        rst = 1'b1;
        START = 1'b0;
        A = 8'h00;
        B = 8'h00;

        // Reset state
        cyc();
        cyc();
        chk("rst_busy", {15'b0, BUSY}, 16'd0);
        chk("rst_done", {15'b0, DONE}, 16'd0);
        chk("rst_product", PRODUCT, 16'h0000);
        rst = 1'b0;
        cyc();

        // Basic, max, cross-nibble, zero
        run_one(8'h03, 8'h02);
        run_one(8'hFF, 8'hFF);
        run_one(8'h12, 8'h34);
        run_one(8'h00, 8'hAB);
        chk("max_value_model", last_prod, 16'h0000);

        // START while busy is ignored
        d0 = n_done;
        launch(8'h0F, 8'h11);
        START = 1'b1;
        A = 8'h01;
        B = 8'h01;
        cyc();
        START = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        chk("ignore_busy_done", 16'(n_done - d0), 16'd1);
        chk("ignore_busy_prod", PRODUCT, 16'h00FF);

        // Back-to-back with START held across completion
        d0 = n_done;
        launch(8'h07, 8'h07);
        START = 1'b1;
        A = 8'h10;
        B = 8'h10;
        sb_q.push_back(16'h0100);
        for (int i = 0; i < 3; i++) cyc();
        cyc();
        chk("b2b_done1", {15'b0, DONE}, 16'd1);
        chk("b2b_prod1", PRODUCT, 16'h0031);
        cyc();
        START = 1'b0;
        chk("b2b_rebusy", {15'b0, BUSY}, 16'd1);
        chk("b2b_done_low", {15'b0, DONE}, 16'd0);
        d0 = last_done_cycle;
        for (int i = 0; i < 4; i++) cyc();
        chk("b2b_done2", {15'b0, DONE}, 16'd1);
        chk("b2b_prod2", PRODUCT, 16'h0100);
        chk("b2b_spacing", 16'(last_done_cycle - d0), 16'd5);
        cyc();
        cyc();

        // Reset during step 2
        d0 = n_done;
        launch(8'h55, 8'h55);
        cyc();
        cyc();
        rst = 1'b1;
        void'(sb_q.pop_back());
        last_prod = 16'h0000;
        cyc();
        rst = 1'b0;
        chk("rst_mid_busy", {15'b0, BUSY}, 16'd0);
        chk("rst_mid_done", {15'b0, DONE}, 16'd0);
        chk("rst_mid_prod", PRODUCT, 16'h0000);
        for (int i = 0; i < 6; i++) cyc();
        chk("rst_mid_no_done", 16'(n_done - d0), 16'd0);
        run_one(8'h55, 8'h55);
        chk("after_rst_prod", PRODUCT, 16'h1C39);

        // Nothing left outstanding
        chk("scoreboard_empty", 16'(sb_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplier_8bit_seq.md
Name: multiplier_8bit_seq

Overview:
Sequential 8x8 unsigned multiplier controller. It time-shares one multiplier_4bit instance across four nibble partial products and accumulates them into a 16-bit result. A START/BUSY/DONE handshake lets a simple host launch and collect products. It is the next step up from the combinational 4-bit core, reusing that core unchanged as its only arithmetic datapath.

Parameters:
None. Operand width is fixed at 8 bits, set by the 4-bit core.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
START  input  1  launch request; sampled only when BUSY=0
A  input  8  multiplicand; captured on accepted START
B  input  8  multiplier; captured on accepted START
BUSY  output  1  high while a multiply is in progress
DONE  output  1  one-cycle pulse; PRODUCT valid and new
PRODUCT  output  16  registered result; held until the next completion

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, BUSY=0, DONE=0, PRODUCT=16'h0000, step=0, accumulator=0, operand regs=0.
- FSM states: IDLE, MUL, FIN. Encoding constants live in the shared package.
- IDLE:
  - START=1 at edge N: capture A and B into Areg and Breg, clear accumulator, step=0, go to MUL.
  - BUSY=1 from edge N.
- MUL: one partial product per cycle. The core is fed combinationally from Areg, Breg and step.
  - step 0: Areg[3:0]*Breg[3:0], added at shift 0
  - step 1: Areg[7:4]*Breg[3:0], added at shift 4
  - step 2: Areg[3:0]*Breg[7:4], added at shift 4
  - step 3: Areg[7:4]*Breg[7:4], added at shift 8
  - Each 8-bit partial product is zero-extended to 16 bits before shifting.
  - Accumulator is 16 bits. No overflow is possible: max result is 255*255 = 0xFE01.
  - step increments by 1 per edge. At edge N+4 (step 3 done), go to FIN.
- Edge N+4 (MUL→FIN transition):
  - PRODUCT <= final accumulated value.
  - DONE=1 and BUSY=0 from this edge.
- FIN: lasts exactly one cycle.
  - START=0 at edge N+5: back to IDLE, DONE=0.
  - START=1 at edge N+5: treated as IDLE acceptance. New operands are captured, go to MUL, DONE=0, BUSY=1. This gives a back-to-back throughput of one result per 5 cycles.
- Latency: DONE is high during the cycle beginning 4 edges after the START-accepting edge.
- START while BUSY=1: ignored. Operands are not recaptured and the sequence is not restarted.
- A and B may change freely after the accepting edge. Only Areg and Breg are used.
- PRODUCT changes only at the MUL→FIN edge or on reset. It is stable at all other times, including during a following multiply.
- Reset mid-operation (rst=1 in MUL or FIN): all registers return to reset values at that edge. The partial result is discarded and no DONE pulse is produced.
- rst has priority over START at the same edge.

Decomposition:
- Shared package: state encodings (IDLE, MUL, FIN); step width (2 bits); step count (4); partial-product shift amounts per step.
- Sub-module: one instance of the existing multiplier_4bit (ports A, B, PRODUCT). No other sub-modules.
- Nibble-select mux and accumulator stay in this module.

Test Plan:
- Basic: A=0x03, B=0x02, START pulse → 4 cycles later DONE=1 for exactly 1 cycle, PRODUCT=0x0006; BUSY high for 4 cycles.
- Max operands: A=0xFF, B=0xFF → PRODUCT=0xFE01. Cross nibbles: A=0x12, B=0x34 → PRODUCT=0x03A8.
- Ignore while busy: start A=0x0F, B=0x11; one cycle later pulse START with A=0x01, B=0x01 → single DONE, PRODUCT=0x00FF, no second DONE.
- Back-to-back: hold START=1 across completion. A=0x07,B=0x07 then A=0x10,B=0x10 → DONE pulses 5 cycles apart, PRODUCT 0x0031 then 0x0100, PRODUCT stable between them.
- Reset mid-operation: start A=0x55, B=0x55; assert rst during MUL step 2 → next cycle BUSY=0, DONE=0, PRODUCT=0x0000, and no DONE follows. A new START then gives PRODUCT=0x1C39.
- Zero operand: A=0x00, B=0xAB → PRODUCT=0x0000, DONE still pulses at normal latency.
